// File: rtl/div_operand_sequencer.sv
// div_operand_sequencer
//
// Buffers dividend/divisor pairs in a small FIFO and feeds them one at a
// time to an external 4-bit divider. The divider's quotient and remainder
// are held on out_* until the consumer takes them. Results come out in
// push order.
//
// Optional feature macro: DIV_ZERO_BYPASS_EN
//   defined   : a pair with divisor 0 skips the divider. It produces a result
//               right away with out_q=4'hF, out_r=dividend and out_dz=1.
//               drop_pulse is tied low.
//   undefined : a pair with divisor 0 is discarded. drop_pulse pulses for
//               one cycle and no result is produced.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   in_valid    in   operand pair offered
//   in_a/in_b   in   dividend / divisor (4 bits each)
//   in_ready    out  FIFO not full
//   div_start   out  one-cycle start pulse to the divider
//   div_a/div_b out  operands to the divider, held until its result is taken
//   div_q/div_r in   divider quotient / remainder
//   div_done    in   divider finished (level)
//   out_valid   out  result held
//   out_q/out_r out  quotient / remainder
//   out_dz      out  result is a divide-by-zero
//   out_ready   in   consumer accepts the result
//   drop_pulse  out  one-cycle pulse when a zero-divisor pair is discarded
//
// State  | meaning
// IDLE   | waiting for a pair in the FIFO; pops the head when one is present
// ISSUE  | div_start high for this single cycle
// WAIT   | waiting for div_done (ignored in the first cycle)
// RESULT | out_valid high, holding the result until out_ready

module div_operand_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       in_ready,
    output logic       div_start,
    output logic [3:0] div_a,
    output logic [3:0] div_b,
    input  logic [3:0] div_q,
    input  logic [3:0] div_r,
    input  logic       div_done,
    output logic       out_valid,
    output logic [3:0] out_q,
    output logic [3:0] out_r,
    output logic       out_dz,
    input  logic       out_ready,
    output logic       drop_pulse
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic          empty;
    logic [3:0]    head_a;
    logic [3:0]    head_b;

    logic wait_first, wait_first_nxt;
    logic load_div;
    logic load_res;
`ifdef DIV_ZERO_BYPASS_EN
    logic load_dz;
`else
    logic drop_nxt;
    logic drop_q;
`endif

    // ---------------- operand FIFO ----------------
    assign in_ready = (count != FULL_CNT);
    assign empty    = (count == '0);
    assign push     = in_valid && in_ready;
    assign head_a   = mem[rd_ptr][7:4];
    assign head_b   = mem[rd_ptr][3:0];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    // Pointers are AW bits wide, so they wrap at DEPTH by themselves.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- sequencing FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_first <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_first <= wait_first_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        wait_first_nxt = wait_first;
        pop            = 1'b0;
        load_div       = 1'b0;
        load_res       = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
        load_dz        = 1'b0;
`else
        drop_nxt       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    load_div = 1'b1;
                    if (head_b == 4'd0) begin
`ifdef DIV_ZERO_BYPASS_EN
                        load_dz   = 1'b1;
                        state_nxt = RESULT;
`else
                        drop_nxt  = 1'b1;
`endif
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_nxt      = WAIT;
                wait_first_nxt = 1'b1;
            end
            WAIT: begin
                // div_done is a level that may still be high from the previous
                // operation, so the first WAIT cycle never samples it.
                wait_first_nxt = 1'b0;
                if (!wait_first && div_done) begin
                    load_res  = 1'b1;
                    state_nxt = RESULT;
                end
            end
            RESULT: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign div_start = (state == ISSUE);
    assign out_valid = (state == RESULT);

    // ---------------- operand / result registers ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_a  <= 4'd0;
            div_b  <= 4'd0;
            out_q  <= 4'd0;
            out_r  <= 4'd0;
            out_dz <= 1'b0;
        end else begin
            if (load_div) begin
                div_a <= head_a;
                div_b <= head_b;
            end
            if (load_res) begin
                out_q  <= div_q;
                out_r  <= div_r;
                out_dz <= 1'b0;
            end
`ifdef DIV_ZERO_BYPASS_EN
            if (load_dz) begin
                out_q  <= 4'hF;
                out_r  <= head_a;
                out_dz <= 1'b1;
            end
`endif
        end
    end

`ifdef DIV_ZERO_BYPASS_EN
    assign drop_pulse = 1'b0;
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_nxt;
        end
    end

    assign drop_pulse = drop_q;
`endif

endmodule

// File: doc/div_operand_sequencer.md
DIV_OPERAND_SEQUENCER -- requirements
Module: div_operand_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, power-of-two operand FIFO depth (2..16).
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_a  input  4  dividend.
REQ-006 SHALL have port in_b  input  4  divisor.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept a pair (FIFO not full).
REQ-008 SHALL have port div_start  output  1  one-cycle start pulse to the 4-bit divider.
REQ-009 SHALL have port div_a  output  4  dividend to divider, stable from start until done is accepted.
REQ-010 SHALL have port div_b  output  4  divisor to divider, stable from start until done is accepted.
REQ-011 SHALL have port div_q  input  4  divider quotient.
REQ-012 SHALL have port div_r  input  4  divider remainder.
REQ-013 SHALL have port div_done  input  1  divider finished; level, may remain high until the next start.
REQ-014 SHALL have port out_valid  output  1  result held.
REQ-015 SHALL have port out_q  output  4  quotient.
REQ-016 SHALL have port out_r  output  4  remainder.
REQ-017 SHALL have port out_dz  output  1  result is a divide-by-zero.
REQ-018 SHALL have port out_ready  input  1  consumer accepts result.
REQ-019 SHALL have port drop_pulse  output  1  one-cycle pulse when a zero-divisor pair is discarded.

Function
REQ-020 SHALL push {in_a,in_b} into the FIFO when in_valid and in_ready are both high at a clock edge; in_ready SHALL be !full, independent of a same-cycle pop.
REQ-021 SHALL use FSM states IDLE, ISSUE, WAIT, RESULT with at most one division in flight.
REQ-022 IDLE: SHALL pop the FIFO head when not empty, latching it into div_a/div_b and moving to ISSUE (or handling it per REQ-034/035 when in_b==0).
REQ-023 ISSUE: SHALL assert div_start for exactly one cycle, then move to WAIT.
REQ-024 WAIT: SHALL ignore div_done in the first WAIT cycle, to mask a stale done from the previous operation.
REQ-025 WAIT: SHALL, from the second cycle on, capture div_q/div_r into out_q/out_r on div_done=1, set out_valid=1 and out_dz=0, and move to RESULT.
REQ-026 RESULT: SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-027 RESULT: SHALL, on out_ready=1, clear out_valid and return to IDLE; the next pop SHALL occur no earlier than the following cycle.
REQ-028 Latency SHALL be: push to div_start of an empty idle block = 2 cycles; div_done to out_valid = 1 cycle.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from a (log2 DEPTH + 1)-bit occupancy count.
REQ-030 Results SHALL emerge in push order.

Reset
REQ-031 While reset=1, the block SHALL force FSM=IDLE, FIFO empty, in_ready=1, and div_start, out_valid, out_dz and drop_pulse to 0.
REQ-032 While reset=1, the block SHALL force div_a, div_b, out_q and out_r to 0.
REQ-033 Reset asserted mid-operation SHALL discard the queued pairs and the in-flight result; div_done arriving after reset deasserts SHALL be ignored while in IDLE.

Configuration
REQ-034 With macro DIV_ZERO_BYPASS_EN defined, a popped pair with b==0 SHALL NOT start the divider; the block SHALL go directly to RESULT with out_q=4'hF, out_r=a, out_dz=1, out_valid=1 the next cycle.
REQ-035 Without DIV_ZERO_BYPASS_EN, a popped pair with b==0 SHALL be discarded with drop_pulse=1 for one cycle, no result produced, FSM remaining in IDLE; drop_pulse SHALL be tied 0 when the macro is defined.

Verification
REQ-036 Push (13,4), divider model answers after 5 cycles, out_ready=1 -> div_start 2 cycles after push; out_q=3, out_r=1, out_dz=0 one cycle after div_done.
REQ-037 Push 5 pairs with DEPTH=4 and div_done withheld -> in_ready=0 after 4 buffered pairs (first already popped); all 5 results then emerge in order.
REQ-038 Hold div_done=1 continuously, push (9,3) -> result taken no earlier than the second WAIT cycle, with out_q=3, out_r=0.
REQ-039 Push (7,0): with DIV_ZERO_BYPASS_EN -> out_q=F, out_r=7, out_dz=1, no div_start; without it -> drop_pulse once, no out_valid.
REQ-040 Hold out_ready=0 for 10 cycles after result (15,2) -> out_q=7, out_r=1 stable throughout, no new div_start.
REQ-041 Assert reset during WAIT with 2 pairs queued -> in_ready=1, out_valid=0, no further div_start after release.
